// File: rtl/mmio_io_pkg.sv
// Shared defaults and sizing helpers for the MMIO I/O buffer.
package mmio_io_pkg;

   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned OUT_W_DEF    = 8;
   localparam int unsigned TX_DEPTH_DEF = 16;
   localparam int unsigned RX_DEPTH_DEF = 4;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; push/pop arrive pre-qualified by the owner.
module sync_fifo
   import mmio_io_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [cnt_w(DEPTH)-1:0]  count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= wdata;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/mmio_io_buffer.sv
// CPU-facing MMIO port: byte-wide TX stream with back-pressure and a word-wide RX capture buffer.
module mmio_io_buffer
   import mmio_io_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned OUT_W    = OUT_W_DEF,
   parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
   parameter int unsigned RX_DEPTH = RX_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cpu_tx_wr,
   input  logic [DATA_W-1:0]           cpu_wdata,
   input  logic                        cpu_rx_rd,
   output logic [DATA_W-1:0]           cpu_rdata,
   output logic                        cpu_stall,
   output logic [OUT_W-1:0]            tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [DATA_W-1:0]           rx_data,
   input  logic                        rx_valid,
   output logic                        rx_overflow,
   output logic [cnt_w(TX_DEPTH)-1:0]  tx_count,
   output logic [cnt_w(RX_DEPTH)-1:0]  rx_count
);

   logic              tx_full;
   logic              tx_empty;
   logic              tx_push;
   logic              tx_pop;
   logic              rx_full;
   logic              rx_empty;
   logic              rx_push;
   logic              rx_pop;
   logic [DATA_W-1:0] rx_head;
   logic              unused_wdata;

   // Only the low OUT_W bits of a store reach the TX stream.
   assign unused_wdata = ^cpu_wdata;

   // A full TX FIFO refuses a store even when the sink drains in the same cycle.
   assign tx_push  = cpu_tx_wr & ~tx_full;
   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;

   // RX has no back-pressure, so a concurrent read frees the slot for the incoming word.
   assign rx_pop  = cpu_rx_rd & ~rx_empty;
   assign rx_push = rx_valid & (~rx_full | rx_pop);

   assign cpu_rdata = rx_pop ? rx_head : '0;
   assign cpu_stall = (cpu_tx_wr & tx_full) | (cpu_rx_rd & rx_empty);

   always_ff @(posedge clk) begin
      if (reset)                             rx_overflow <= 1'b0;
      else if (rx_valid && rx_full && !rx_pop) rx_overflow <= 1'b1;
   end

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (cpu_wdata[OUT_W-1:0]),
      .head  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_data),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

endmodule

// File: tb/tb_mmio_io_buffer.sv
// Scoreboard bench for mmio_io_buffer: directed scenarios followed by randomized traffic.
module tb_mmio_io_buffer;

   localparam int DATA_W = 32;
   localparam int OUT_W  = 8;
   localparam int TXD    = 16;
   localparam int RXD    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_tx_wr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rx_rd;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic [OUT_W-1:0]  tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_overflow;
   logic [4:0]        tx_count;
   logic [2:0]        rx_count;

   always #5 clk = ~clk;

   mmio_io_buffer #(
      .DATA_W   (DATA_W),
      .OUT_W    (OUT_W),
      .TX_DEPTH (TXD),
      .RX_DEPTH (RXD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_tx_wr   (cpu_tx_wr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rx_rd   (cpu_rx_rd),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_overflow (rx_overflow),
      .tx_count    (tx_count),
      .rx_count    (rx_count)
   );

   typedef struct {
      bit          chk;
      bit          tx_valid;
      int          tx_count;
      int          rx_count;
      bit          ovf;
      bit          stall;
      logic [31:0] rdata;
   } status_t;

   status_t     st_q[$];
   logic [7:0]  tx_sb[$];
   logic [31:0] rx_m[$];
   bit          ovf_m = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queues for both FIFOs; runs after inputs settle each cycle.
   initial begin : model
      status_t s;
      int      txs;
      int      rxs;
      bit      rd_hit;
      forever begin
         @(posedge clk);
         #2;
         txs        = tx_sb.size();
         rxs        = rx_m.size();
         s.chk      = !reset;
         s.tx_valid = (txs != 0);
         s.tx_count = txs;
         s.rx_count = rxs;
         s.ovf      = ovf_m;
         s.stall    = (cpu_tx_wr && txs == TXD) || (cpu_rx_rd && rxs == 0);
         s.rdata    = '0;
         if (reset) begin
            tx_sb.delete();
            rx_m.delete();
            ovf_m = 1'b0;
         end else begin
            if (cpu_tx_wr && txs < TXD) tx_sb.push_back(cpu_wdata[7:0]);
            rd_hit = cpu_rx_rd && rxs > 0;
            if (rd_hit) s.rdata = rx_m.pop_front();
            if (rx_valid) begin
               if (rxs < RXD || rd_hit) rx_m.push_back(rx_data);
               else                     ovf_m = 1'b1;
            end
         end
         st_q.push_back(s);
      end
   end

   // Monitor: compares per-cycle status and every TX handshake against the scoreboard.
   initial begin : monitor
      status_t s;
      forever begin
         @(negedge clk);
         if (st_q.size() != 0) begin
            s = st_q.pop_front();
            if (s.chk) begin
               check("tx_valid",    64'(tx_valid),    64'(s.tx_valid));
               check("tx_count",    64'(tx_count),    64'(s.tx_count));
               check("rx_count",    64'(rx_count),    64'(s.rx_count));
               check("rx_overflow", 64'(rx_overflow), 64'(s.ovf));
               check("cpu_stall",   64'(cpu_stall),   64'(s.stall));
               check("cpu_rdata",   64'(cpu_rdata),   64'(s.rdata));
            end
         end
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL tx_data: got byte 0x%0h with none expected at %0t", tx_data, $time);
            end else begin
               check("tx_data", 64'(tx_data), 64'(tx_sb.pop_front()));
            end
         end
      end
   end

   task automatic cyc(input bit rst, input bit wr, input logic [31:0] wd, input bit rd,
                      input bit rxv, input logic [31:0] rxd, input bit rdy);
      reset     = rst;
      cpu_tx_wr = wr & ~rst;
      cpu_wdata = wd;
      cpu_rx_rd = rd & ~rst;
      rx_valid  = rxv & ~rst;
      rx_data   = rxd;
      tx_ready  = rdy & ~rst;
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int pw;
      int pr;
      int pv;
      int py;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);

      // Three stores streamed out back to back.
      cyc(0, 1, 32'hFFFF_FF41, 0, 0, 0, 1);
      cyc(0, 1, 32'h0000_0042, 0, 0, 0, 1);
      cyc(0, 1, 32'h1234_5643, 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);

      // Fill TX, stall on the 17th store, release one slot, then drain.
      for (int i = 0; i < 17; i++) cyc(0, 1, 32'hA0 + 32'(i), 0, 0, 0, 0);
      cyc(0, 1, 32'hB0, 0, 0, 0, 1);
      cyc(0, 1, 32'hB0, 0, 0, 0, 0);
      repeat (20) cyc(0, 0, 0, 0, 0, 0, 1);

      // RX overflow, then read back the survivors and one read on empty.
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'h10 + 32'(i), 0);
      repeat (5) cyc(0, 0, 0, 1, 0, 0, 0);

      // Full RX with a concurrent read and strobe.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'h20 + 32'(i), 0);
      cyc(0, 0, 0, 1, 1, 32'h24, 0);
      repeat (5) cyc(0, 0, 0, 1, 0, 0, 0);

      // Read on empty, then a strobe, then a read.
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h55AA_0001, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);

      // Reset with TX holding data and the overflow flag set.
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h60 + 32'(i), 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'h70 + 32'(i), 0);
      cyc(1, 1, 32'h99, 1, 1, 32'h99, 1);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic with varying pressure and occasional resets.
      for (int blk = 0; blk < 10; blk++) begin
         pw = int'($urandom_range(10, 95));
         pr = int'($urandom_range(5, 95));
         pv = int'($urandom_range(5, 95));
         py = int'($urandom_range(5, 95));
         for (int c = 0; c < 250; c++)
            cyc($urandom_range(0, 399) == 0,
                int'($urandom_range(0, 99)) < pw, $urandom,
                int'($urandom_range(0, 99)) < pr,
                int'($urandom_range(0, 99)) < pv, $urandom,
                int'($urandom_range(0, 99)) < py);
      end
      repeat (25) cyc(0, 0, 0, 1, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mmio_io_buffer.md
MMIO_IO_BUFFER -- requirements
Module: mmio_io_buffer

Interface
REQ-001 Parameter DATA_W, default 32: CPU word width.
REQ-002 Parameter OUT_W, default 8: output byte width, OUT_W <= DATA_W.
REQ-003 Parameter TX_DEPTH, default 16: TX FIFO entries, power of 2, >= 2.
REQ-004 Parameter RX_DEPTH, default 4: RX FIFO entries, power of 2, >= 2.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpu_tx_wr  in  1  CPU store to the output port.
REQ-008 cpu_wdata  in  DATA_W  store data; only bits [OUT_W-1:0] are kept.
REQ-009 cpu_rx_rd  in  1  CPU load from the input port.
REQ-010 cpu_rdata  out  DATA_W  load data.
REQ-011 cpu_stall  out  1  CPU must hold the current access.
REQ-012 tx_data  out  OUT_W  output byte.
REQ-013 tx_valid  out  1  tx_data valid.
REQ-014 tx_ready  in  1  sink accepts tx_data.
REQ-015 rx_data  in  DATA_W  received word.
REQ-016 rx_valid  in  1  one-cycle strobe; no back-pressure exists.
REQ-017 rx_overflow  out  1  sticky flag: a received word was dropped.
REQ-018 tx_count  out  $clog2(TX_DEPTH+1)  TX occupancy.
REQ-019 rx_count  out  $clog2(RX_DEPTH+1)  RX occupancy.

Function
REQ-020 TX push occurs when cpu_tx_wr=1 and TX not full; the FIFO stores cpu_wdata[OUT_W-1:0].
REQ-021 tx_valid = TX not empty, driven from registered state; tx_data = head entry.
REQ-022 TX pop occurs when tx_valid=1 and tx_ready=1; tx_data/tx_valid may change only after a pop or a push into an empty FIFO.
REQ-023 Latency: a push into an empty TX FIFO raises tx_valid in the next cycle with that byte.
REQ-024 TX full: a push is blocked even if a pop occurs in the same cycle; the pop proceeds and tx_count decrements.
REQ-025 TX simultaneous push and pop when not full and not empty: both proceed; tx_count is unchanged.
REQ-026 RX push occurs when rx_valid=1 and (RX not full, or a pop occurs in the same cycle).
REQ-027 rx_valid=1 with RX full and no concurrent pop: the word is dropped, contents are unchanged, and rx_overflow sets and holds until reset.
REQ-028 RX pop occurs when cpu_rx_rd=1 and RX not empty; cpu_rdata = head combinationally (show-ahead) in that cycle.
REQ-029 cpu_rdata = 0 whenever no RX pop occurs.
REQ-030 cpu_stall = (cpu_tx_wr & TX full) | (cpu_rx_rd & RX empty), combinational; no state changes for a stalled access.
REQ-031 cpu_tx_wr and cpu_rx_rd may both be asserted in one cycle; they are handled independently.
REQ-032 Pointers wrap modulo depth; counts saturate at neither 0 nor depth (unreachable by construction).

Reset
REQ-033 When reset=1, the following clear at the clock edge: pointers, tx_count=0, rx_count=0, tx_valid=0, rx_overflow=0, cpu_stall driven from the cleared state.
REQ-034 Reset mid-transfer discards all FIFO contents; tx_data is don't-care while tx_valid=0.
REQ-035 Inputs are ignored during the reset cycle.

Structure
REQ-036 Package mmio_io_pkg holds default parameter constants and a count-width function.
REQ-037 One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head), is instantiated for TX and for RX.
REQ-038 Full/empty detection uses count or an extra pointer wrap bit; no combinational path from tx_ready to tx_valid.

Verification
REQ-039 Scenario 1: write 0x41, 0x42, 0x43 with tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive cycles, the first one cycle after the first write.
REQ-040 Scenario 2: tx_ready=0, 17 writes with TX_DEPTH=16 -> cpu_stall=1 on the 17th write and tx_count=16; raise tx_ready for one cycle -> the stall clears the next cycle and the 17th byte is accepted.
REQ-041 Scenario 3: 5 rx_valid strobes (0x10..0x14) with RX_DEPTH=4 and no reads -> rx_overflow=1 and rx_count=4; 4 reads return 0x10..0x13.
REQ-042 Scenario 4: RX full, rx_valid and cpu_rx_rd in the same cycle -> read returns the oldest word, the new word is stored, rx_overflow stays 0.
REQ-043 Scenario 5: cpu_rx_rd with RX empty -> cpu_stall=1, cpu_rdata=0; rx_valid next cycle -> the following read returns that word.
REQ-044 Scenario 6: reset asserted with TX holding 3 bytes and rx_overflow=1 -> next cycle tx_valid=0, counts=0, rx_overflow=0.
